// File: rtl/zx_bus_dma.sv
// Bus-master block-transfer sequencer: requests the Z80 bus, strobes ZX81 memory byte by byte,
// streams read data out (or takes write data in), then hands the bus back.
module zx_bus_dma #(
    parameter int ACK_TIMEOUT   = 1024,
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [15:0] cmd_addr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic [7:0]  wr_data_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        busrq_n_o,
    input  logic        busak_n_i,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    output logic        mem_rd_n_o,
    output logic        mem_wr_n_o,
    output logic        mem_drive_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // state     | meaning
    // S_IDLE    | waiting for a command, bus not requested
    // S_REQ     | busrq asserted, waiting for ack with timeout
    // S_WAIT_WR | bus held, waiting for the next write byte
    // S_SETUP   | address/data driven, strobes high
    // S_STROBE  | read or write strobe low
    // S_HOLD    | strobes high, address/data held
    // S_RD_OUT  | bus held, read byte offered to consumer
    // S_RELEASE | bus request dropped, waiting for ack to go away
    // S_DONE    | done pulse
    // S_ABORT   | error pulse (timeout or lost ack), bus already released

    localparam int CMAX = (ACK_TIMEOUT > STROBE_CYCLES) ? ACK_TIMEOUT : STROBE_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LOAD = CW'(STROBE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT_WR, S_SETUP, S_STROBE,
        S_HOLD, S_RD_OUT, S_RELEASE, S_DONE, S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      busak_sync_q;
    logic            write_q, write_d;
    logic [15:0]     addr_q, addr_d;
    logic [8:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      rdat_q, rdat_d;
    logic            ack;
    logic            in_active;

    assign ack       = ~busak_sync_q[1];
    assign in_active = (state_q == S_WAIT_WR) || (state_q == S_SETUP) || (state_q == S_STROBE)
                    || (state_q == S_HOLD) || (state_q == S_RD_OUT);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            busak_sync_q <= 2'b11;
            write_q      <= 1'b0;
            addr_q       <= 16'h0000;
            rem_q        <= 9'd0;
            cnt_q        <= '0;
            dout_q       <= 8'h00;
            rdat_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            busak_sync_q <= {busak_sync_q[0], busak_n_i};
            write_q      <= write_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            rdat_q       <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rdat_d  = rdat_q;
        // Losing the bus overrides anything the current byte wanted to do.
        if (in_active && !ack) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        write_d = cmd_write_i;
                        addr_d  = cmd_addr_i;
                        rem_d   = (cmd_len_i == 8'd0) ? 9'd256 : {1'b0, cmd_len_i};
                        cnt_d   = ACK_LOAD;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        state_d = write_q ? S_WAIT_WR : S_SETUP;
                    end else if (cnt_q == '0) begin
                        state_d = S_ABORT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WAIT_WR: begin
                    if (wr_valid_i) begin
                        dout_d  = wr_data_i;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt_d   = STB_LOAD;
                    state_d = S_STROBE;
                end
                S_STROBE: begin
                    if (cnt_q == '0) begin
                        if (!write_q) rdat_d = mem_din_i;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (write_q) begin
                        addr_d  = addr_q + 16'd1;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? S_RELEASE : S_WAIT_WR;
                    end else begin
                        state_d = S_RD_OUT;
                    end
                end
                S_RD_OUT: begin
                    if (rd_ready_i) begin
                        addr_d  = addr_q + 16'd1;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? S_RELEASE : S_SETUP;
                    end
                end
                S_RELEASE: begin
                    if (!ack) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        busrq_n_o   = !((state_q == S_REQ) || in_active);
        mem_drive_o = in_active;
        // Gating with ack pulls the strobes high as soon as the loss is seen.
        mem_rd_n_o  = !((state_q == S_STROBE) && !write_q && ack);
        mem_wr_n_o  = !((state_q == S_STROBE) &&  write_q && ack);
        wr_ready_o  = (state_q == S_WAIT_WR) && ack;
        rd_valid_o  = (state_q == S_RD_OUT) && ack;
        done_o      = (state_q == S_DONE);
        error_o     = (state_q == S_ABORT);
        mem_addr_o  = addr_q;
        mem_dout_o  = dout_q;
        rd_data_o   = rdat_q;
    end

endmodule

// File: tb/tb_zx_bus_dma.sv
// Randomized bench for zx_bus_dma: Z80 bus-ack responder, memory model and a byte-level
// reference of what each transfer must do on the bus and on the stream ports.
module tb_zx_bus_dma;

    localparam int ACK_TIMEOUT   = 1024;
    localparam int STROBE_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready;
    logic        busrq_n, busak_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_rd_n, mem_wr_n, mem_drive;
    logic        busy, done, error;

    zx_bus_dma #(.ACK_TIMEOUT(ACK_TIMEOUT), .STROBE_CYCLES(STROBE_CYCLES)) dut (
        .clock_i(clock), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .busrq_n_o(busrq_n), .busak_n_i(busak_n),
        .mem_addr_o(mem_addr), .mem_dout_o(mem_dout), .mem_din_i(mem_din),
        .mem_rd_n_o(mem_rd_n), .mem_wr_n_o(mem_wr_n), .mem_drive_o(mem_drive),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus-side memory and the bench's own expectation of its contents
    logic [7:0] mem     [65536];
    logic [7:0] ref_mem [65536];
    assign mem_din = mem[mem_addr];

    // Monitor: strobe runs, pulses, timing marks
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, strobe_total = 0;
    int t_rq_fall = -1, t_err = -1, busak_hi = 0, strobe_noack = 0;
    int rd_run = 0, wr_run = 0;
    logic        busrq_prev = 1'b1;
    logic [15:0] run_addr;
    logic [7:0]  run_dat;
    logic [15:0] rd_addr_q[$], wr_addr_q[$];
    int          rd_len_q[$], wr_len_q[$];
    logic [7:0]  wr_dat_q[$];

    always @(negedge clock) begin
        cyc++;
        if (done) done_cnt++;
        if (error) begin err_cnt++; t_err = cyc; end
        if (done && error) both_cnt++;
        if (!busrq_n && busrq_prev) t_rq_fall = cyc;
        busrq_prev = busrq_n;
        busak_hi = busak_n ? busak_hi + 1 : 0;
        if ((!mem_rd_n || !mem_wr_n) && busak_hi >= 3) strobe_noack++;
        if (!mem_rd_n) begin
            if (rd_run == 0) run_addr = mem_addr;
            rd_run++; strobe_total++;
        end else if (rd_run != 0) begin
            rd_addr_q.push_back(run_addr); rd_len_q.push_back(rd_run); rd_run = 0;
        end
        if (!mem_wr_n) begin
            if (wr_run == 0) begin run_addr = mem_addr; run_dat = mem_dout; end
            wr_run++; strobe_total++;
        end else if (wr_run != 0) begin
            wr_addr_q.push_back(run_addr); wr_dat_q.push_back(run_dat);
            wr_len_q.push_back(wr_run); mem[run_addr] = run_dat; wr_run = 0;
        end
    end

    // Z80 side: grants the bus ack_dly cycles after a request, drops it when the request goes
    bit ack_en  = 1'b1;
    int ack_dly = 5;
    int ack_wait = 0;
    initial begin
        busak_n = 1'b1;
        forever begin
            @(negedge clock);
            if (!ack_en || busrq_n) begin
                busak_n = 1'b1; ack_wait = 0;
            end else if (busak_n) begin
                ack_wait++;
                if (ack_wait >= ack_dly) busak_n = 1'b0;
            end
        end
    end

    logic [7:0] wr_exp[$];
    logic [7:0] got_rd[$];
    bit xfer_end;
    int lose_after = -1, stall_byte = -1, stall_cyc = 0;
    int rd_stall_max = 0, wr_gap_max = 0;
    bit offer_second = 1'b0;
    int stall_bad, hold_bad, rej_bad;

    task automatic issue_cmd(input bit wr, input logic [15:0] a, input logic [7:0] l);
        int k = 0;
        @(negedge clock);
        while (!cmd_ready && k < 5000) begin @(negedge clock); k++; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_wr(input int n);
        for (int i = 0; i < n && !xfer_end; i++) begin
            int gap = (i == stall_byte) ? stall_cyc : $urandom_range(wr_gap_max, 0);
            int k = 0;
            for (int g = 0; g < gap && !xfer_end; g++) begin
                @(negedge clock);
                if (wr_ready && (mem_wr_n !== 1'b1 || busrq_n !== 1'b0 || mem_drive !== 1'b1))
                    stall_bad++;
            end
            wr_valid = 1'b1; wr_data = wr_exp[i];
            while (!wr_ready && !xfer_end && k < 5000) begin @(negedge clock); k++; end
            @(negedge clock);
            wr_valid = 1'b0;
        end
    endtask

    task automatic drain_rd(input int n);
        for (int i = 0; i < n && !xfer_end; i++) begin
            int k = 0;
            int st;
            while (!rd_valid && !xfer_end && k < 5000) begin @(negedge clock); k++; end
            if (xfer_end || k >= 5000) break;
            st = $urandom_range(rd_stall_max, 0);
            for (int g = 0; g < st; g++) begin
                @(negedge clock);
                if (rd_valid !== 1'b1 || busrq_n !== 1'b0 || mem_rd_n !== 1'b1) hold_bad++;
            end
            rd_ready = 1'b1; got_rd.push_back(rd_data);
            @(negedge clock);
            rd_ready = 1'b0;
            if (rd_valid !== 1'b0) hold_bad++;
            if (i == lose_after) begin ack_en = 1'b0; break; end
        end
    endtask

    task automatic offer_cmd();
        repeat (3) @(negedge clock);
        for (int g = 0; g < 10; g++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h1234; cmd_len = 8'd7;
            if (cmd_ready !== 1'b0) rej_bad++;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_xfer(input bit wr, input logic [15:0] a, input logic [7:0] l, input string tag);
        int n = (l == 8'd0) ? 256 : int'(l);
        int k = 0;
        rd_addr_q.delete(); wr_addr_q.delete(); rd_len_q.delete(); wr_len_q.delete();
        wr_dat_q.delete(); got_rd.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
        xfer_end = 1'b0; stall_bad = 0; hold_bad = 0; rej_bad = 0;
        issue_cmd(wr, a, l);
        fork
            begin if (wr) feed_wr(n); else drain_rd(n); end
            begin if (offer_second) offer_cmd(); end
            begin
                while (done_cnt == 0 && err_cnt == 0 && k < 20000) begin @(negedge clock); k++; end
                xfer_end = 1'b1;
            end
        join
        chk({tag, "_bound"}, (k < 20000) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_ok(input bit wr, input logic [15:0] a, input logic [7:0] l, input string tag);
        int n = (l == 8'd0) ? 256 : int'(l);
        logic [15:0] ad;
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_both"}, both_cnt, 0);
        chk({tag, "_busrq_end"}, busrq_n, 1'b1);
        chk({tag, "_cmdrdy_end"}, cmd_ready, 1'b1);
        chk({tag, "_stall"}, stall_bad, 0);
        chk({tag, "_hold"}, hold_bad, 0);
        if (wr) begin
            chk({tag, "_nwr"}, wr_addr_q.size(), n);
            chk({tag, "_nrd"}, rd_addr_q.size(), 0);
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                ad = a + 16'(i);
                chk($sformatf("%s_wa%0d", tag, i), wr_addr_q[i], ad);
                chk($sformatf("%s_wd%0d", tag, i), wr_dat_q[i], wr_exp[i]);
                chk($sformatf("%s_wl%0d", tag, i), wr_len_q[i], STROBE_CYCLES);
            end
            for (int i = 0; i < n; i++) ref_mem[a + 16'(i)] = wr_exp[i];
        end else begin
            chk({tag, "_nrd"}, rd_addr_q.size(), n);
            chk({tag, "_ngot"}, got_rd.size(), n);
            for (int i = 0; i < n && i < rd_addr_q.size() && i < got_rd.size(); i++) begin
                ad = a + 16'(i);
                chk($sformatf("%s_rd%0d", tag, i), got_rd[i], ref_mem[ad]);
                chk($sformatf("%s_ra%0d", tag, i), rd_addr_q[i], ad);
                chk($sformatf("%s_rl%0d", tag, i), rd_len_q[i], STROBE_CYCLES);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {22'b0, busrq_n, mem_rd_n, mem_wr_n, mem_drive, rd_valid, wr_ready,
                            done, error, busy, cmd_ready}, 32'h381);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_dout"}, mem_dout, 0);
        chk({tag, "_rdat"}, rd_data, 0);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  l;
        bit          w;
        int          k;
        int          sb;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0;
        wr_data = 8'h0; wr_valid = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clock);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clock);

        // Read 3 bytes from 0x4000
        mem[16'h4000] = 8'h11; mem[16'h4001] = 8'h22; mem[16'h4002] = 8'h33;
        ref_mem[16'h4000] = 8'h11; ref_mem[16'h4001] = 8'h22; ref_mem[16'h4002] = 8'h33;
        ack_dly = 5;
        do_xfer(1'b0, 16'h4000, 8'd3, "rd3");
        check_ok(1'b0, 16'h4000, 8'd3, "rd3");
        if (got_rd.size() == 3) begin
            chk("rd3_b0", got_rd[0], 8'h11);
            chk("rd3_b2", got_rd[2], 8'h33);
        end

        // Write 2 bytes across 0x7FFF/0x8000, second byte stalled
        wr_exp.delete(); wr_exp.push_back(8'hA5); wr_exp.push_back(8'h5A);
        stall_byte = 1; stall_cyc = 10;
        do_xfer(1'b1, 16'h7FFF, 8'd2, "wr2");
        check_ok(1'b1, 16'h7FFF, 8'd2, "wr2");
        stall_byte = -1;
        chk("wr2_mem8000", mem[16'h8000], 8'h5A);

        // Address wrap with len 0 (256 bytes)
        ack_dly = 2; rd_stall_max = 1;
        do_xfer(1'b0, 16'hFFFF, 8'd0, "wrap");
        check_ok(1'b0, 16'hFFFF, 8'd0, "wrap");

        // Random transfers; writes are read back
        rd_stall_max = 3; wr_gap_max = 3;
        for (int t = 0; t < 12; t++) begin
            w = 1'($urandom);
            a = 16'($urandom);
            l = 8'($urandom_range(8, 1));
            ack_dly = $urandom_range(6, 1);
            wr_exp.delete();
            for (int i = 0; i < int'(l); i++) wr_exp.push_back(8'($urandom));
            do_xfer(w, a, l, $sformatf("rnd%0d", t));
            check_ok(w, a, l, $sformatf("rnd%0d", t));
            if (w) begin
                do_xfer(1'b0, a, l, $sformatf("rbk%0d", t));
                check_ok(1'b0, a, l, $sformatf("rbk%0d", t));
            end
        end

        // Second command offered while busy is not taken
        rd_stall_max = 0; ack_dly = 3; offer_second = 1'b1;
        do_xfer(1'b0, 16'h5000, 8'd4, "rej");
        offer_second = 1'b0;
        check_ok(1'b0, 16'h5000, 8'd4, "rej");
        chk("rej_cmdrdy", rej_bad, 0);
        repeat (10) @(negedge clock);
        chk("rej_idle", busy, 1'b0);
        chk("rej_nostart", rd_addr_q.size() + wr_addr_q.size(), 4);

        // Ack timeout
        ack_en = 1'b0; t_rq_fall = -1; t_err = -1;
        sb = strobe_total;
        do_xfer(1'b0, 16'h1000, 8'd2, "tmo");
        chk("tmo_err", err_cnt, 1);
        chk("tmo_done", done_cnt, 0);
        chk("tmo_delay", t_err - t_rq_fall, ACK_TIMEOUT);
        chk("tmo_nostrobe", strobe_total - sb, 0);
        chk("tmo_busrq", busrq_n, 1'b1);
        chk("tmo_cmdrdy", cmd_ready, 1'b1);
        ack_en = 1'b1;

        // Ack lost after the second byte of a 4-byte read
        ack_dly = 3; lose_after = 1;
        do_xfer(1'b0, 16'h3000, 8'd4, "lost");
        chk("lost_err", err_cnt, 1);
        chk("lost_done", done_cnt, 0);
        chk("lost_both", both_cnt, 0);
        chk("lost_ngot", got_rd.size(), 2);
        if (got_rd.size() == 2) chk("lost_b1", got_rd[1], ref_mem[16'h3001]);
        chk("lost_noack_strobe", strobe_noack, 0);
        chk("lost_idle", {busrq_n, mem_rd_n, mem_wr_n, mem_drive, busy}, 5'b11100);
        lose_after = -1; ack_en = 1'b1;

        // Reset in the middle of a read strobe
        issue_cmd(1'b0, 16'h2000, 8'd4);
        k = 0;
        while (mem_rd_n !== 1'b0 && k < 200) begin @(negedge clock); k++; end
        chk("rst_reach_strobe", mem_rd_n, 1'b0);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_mid");
        @(negedge clock);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_after_busy", busy, 1'b0);

        do_xfer(1'b0, 16'h0100, 8'd2, "post");
        check_ok(1'b0, 16'h0100, 8'd2, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zx_bus_dma.md
Name: zx_bus_dma

Overview:
- Bus-master sequencer that lets the command-line interpreter read or write ZX81 memory.
- Takes a block-transfer command (address, length, direction) from the cmdline block.
- Requests the Z80 bus via busrq_n, waits for busak_n, then performs byte-wise memory strobes.
- Streams read data back toward the UART send path, then releases the bus.

Parameters:
- ACK_TIMEOUT, 1024: clock cycles to wait for bus acknowledge before aborting.
- STROBE_CYCLES, 2: cycles mem_rd_n/mem_wr_n held low per byte (minimum 1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready
- cmd_write  in  1  1 = write memory, 0 = read memory
- cmd_addr  in  16  start address
- cmd_len  in  8  byte count; 0 means 256
- wr_data  in  8  write byte
- wr_valid  in  1  write byte offered
- wr_ready  out  1  write byte accepted on wr_valid&wr_ready
- rd_data  out  8  read byte
- rd_valid  out  1  read byte held until rd_ready
- rd_ready  in  1  consumer takes read byte
- busrq_n  out  1  Z80 bus request, active low
- busak_n  in  1  Z80 bus acknowledge, active low, asynchronous to clock
- mem_addr  out  16  memory address
- mem_dout  out  8  write data
- mem_din  in  8  read data
- mem_rd_n  out  1  read strobe, active low
- mem_wr_n  out  1  write strobe, active low
- mem_drive  out  1  enables our address/data/strobe drivers onto the bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on timeout or lost acknowledge

Behaviour:
- **Reset values:** on reset, all of the following take effect immediately (asynchronously), including mid-transfer, which drops the bus at once:
  - busrq_n=1, mem_rd_n=1, mem_wr_n=1, mem_drive=0
  - rd_valid=0, wr_ready=0, done=0, error=0, busy=0
  - cmd_ready=1, mem_addr=0, mem_dout=0, rd_data=0
  - state IDLE
- **busak_n synchronisation:** synchronised through 2 flops; "ack" below means the synchronised busak_n is 0.
- **IDLE:** on cmd_valid&cmd_ready, latch addr, len (0→256, 9-bit remaining count) and direction; next state REQ.
  - cmd_valid is ignored whenever cmd_ready=0.
- **REQ:** busrq_n=0; a timeout counter runs from 0.
  - ack → ACTIVE.
  - Counter reaches ACK_TIMEOUT-1 → busrq_n=1, error pulse, back to IDLE.
- **ACTIVE (per byte):** busrq_n stays 0.
  - Write: WAIT_WR, with wr_ready=1 until wr_valid; latch wr_data into mem_dout, wr_ready=0.
  - SETUP: mem_drive=1, mem_addr=current address, strobes high; lasts 1 cycle.
  - STROBE: mem_rd_n or mem_wr_n low for exactly STROBE_CYCLES cycles. A read samples mem_din on the final strobe cycle into rd_data.
  - HOLD: strobes high, address/data held 1 cycle.
  - Read: then RD_OUT, with rd_valid=1 until rd_ready; rd_valid drops the cycle after acceptance.
  - Then address+1 (wraps 0xFFFF→0x0000, 16-bit), remaining-1.
  - remaining=0 → RELEASE; otherwise SETUP (read) or WAIT_WR (write).
- **Back-pressure:** stalls in WAIT_WR/RD_OUT keep the bus held, with mem_drive=1 and strobes inactive.
- **RELEASE:** mem_drive=0, busrq_n=1. Wait until synchronised busak_n=1, then done pulse and IDLE.
- **Lost acknowledge:** if busak_n deasserts (synchronised) in any ACTIVE state, the byte is abandoned. Strobes return high immediately, then error pulse, RELEASE behaviour without done, and IDLE.
- **Pulse exclusivity:** done and error are never asserted together.

Test Plan:
- **Read 3 bytes:** cmd read addr 0x4000, len 3; drive busak_n low 5 cycles after busrq_n falls; memory returns 0x11,0x22,0x33.
  - Required: rd_data 0x11,0x22,0x33 in order.
  - Required: mem_rd_n low exactly 2 cycles per byte; mem_addr 0x4000..0x4002.
  - Required: busrq_n=1 after the last byte; done pulses once after busak_n returns high.
- **Write 2 bytes with stall:** write addr 0x7FFF, len 2, data 0xA5, 0x5A; delay the second wr_valid 10 cycles.
  - Required: writes land at 0x7FFF and 0x8000; mem_wr_n idle during the stall; busrq_n held low throughout.
- **Wrap and len=0:** read addr 0xFFFF, len 0.
  - Required: 256 reads, addresses 0xFFFF, 0x0000 .. 0x00FE; done once.
- **Timeout:** busak_n held high.
  - Required: error pulse ACK_TIMEOUT cycles after busrq_n falls; busrq_n returns 1; cmd_ready=1; no strobe ever asserted.
- **Lost ack / reset:**
  - Raise busak_n mid-way through a 4-byte read → strobes high, error pulse, no done.
  - Separately, assert reset during STROBE → all outputs at reset values the same cycle.
- **Busy rejection:** offer a second cmd_valid during a transfer.
  - Required: it is not accepted; the first transfer completes unchanged.
